// File: rtl/stage_ex.sv
// stage_ex: signed 24-bit execute stage; registers ALU result and a merged PSTATE flag write
module stage_ex (
  input  logic        iw_clk,
  input  logic        iw_rst,
  input  logic        iw_stall,
  input  logic        iw_flush,
  input  logic [7:0]  iw_opc,
  input  logic [23:0] iw_instr,
  input  logic [11:0] iw_imm12_val,
  input  logic [3:0]  iw_cc,
  input  logic [3:0]  iw_tgt_gp,
  input  logic        iw_tgt_gp_we,
  input  logic [23:0] iw_tgt_gp_val,
  input  logic [23:0] iw_src_gp_val,
  input  logic [47:0] iw_src_sr_val,
  input  logic [47:0] iw_pstate_val,
  output logic [7:0]  ow_opc,
  output logic [3:0]  ow_tgt_gp,
  output logic        ow_tgt_gp_we,
  output logic [23:0] ow_result,
  output logic        ow_sr_aux_we,
  output logic [1:0]  ow_sr_aux_addr,
  output logic [47:0] ow_sr_aux_result
);
  localparam logic [7:0] NEGSR = 8'h10, ADDSR = 8'h11, SUBSR = 8'h12, SHRSR = 8'h13,
                         CMPSR = 8'h14, TSTSR = 8'h15, ADDSI = 8'h20, SUBSI = 8'h21,
                         SHRSI = 8'h22, CMPSI = 8'h23, MOVSI = 8'h24, MCCSI = 8'h25;
  localparam logic [3:0] CC_AL = 4'd0, CC_EQ = 4'd1, CC_NE = 4'd2, CC_LT = 4'd3, CC_GE = 4'd4,
                         CC_MI = 4'd5, CC_PL = 4'd6, CC_CS = 4'd7, CC_CC = 4'd8;
  logic [23:0] t, b, imm12, imm8, shr, r, f;
  logic [24:0] sum, dif;
  logic [4:0]  sh;
  logic [3:0]  fl;
  logic [47:0] p;
  logic        shc, taken, wr, sr_we, set_zn, set_c, set_v, c_f, v_f;
  assign t     = iw_tgt_gp_val;
  assign imm12 = {{12{iw_imm12_val[11]}}, iw_imm12_val};
  assign imm8  = {{16{iw_instr[7]}}, iw_instr[7:0]};
  // all immediate-form opcodes live in the 0x2x row
  assign b     = iw_opc[7:4] == 4'h2 ? imm12 : iw_src_gp_val;
  assign sum   = {1'b0, t} + {1'b0, b};
  assign dif   = {1'b0, t} - {1'b0, b};
  assign sh    = b[4:0];
  assign shr   = $signed(t) >>> sh;
  assign shc   = sh == 5'd0 ? 1'b0 : sh > 5'd24 ? t[23] : t[sh - 5'd1];
  assign fl    = iw_src_sr_val[3:0];
  assign ow_sr_aux_addr = 2'd2;
  always_comb begin
    case (iw_cc)
      CC_AL:   taken = 1'b1;
      CC_EQ:   taken = fl[0];
      CC_NE:   taken = !fl[0];
      CC_LT:   taken = fl[1] ^ fl[3];
      CC_GE:   taken = !(fl[1] ^ fl[3]);
      CC_MI:   taken = fl[1];
      CC_PL:   taken = !fl[1];
      CC_CS:   taken = fl[2];
      CC_CC:   taken = !fl[2];
      default: taken = 1'b0;
    endcase
  end
  always_comb begin
    r = '0;
    wr = 1'b1;
    sr_we = 1'b1;
    set_zn = 1'b1;
    set_c = 1'b0;
    set_v = 1'b0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (iw_opc)
      NEGSR: begin
        r = -t;
        c_f = |t;
        v_f = t == 24'h800000;
        set_c = 1'b1;
        set_v = 1'b1;
      end
      ADDSR, ADDSI: begin
        r = sum[23:0];
        c_f = sum[24];
        v_f = t[23] == b[23] && sum[23] != t[23];
        set_c = 1'b1;
        set_v = 1'b1;
      end
      SUBSR, SUBSI: begin
        r = dif[23:0];
        c_f = dif[24];
        v_f = t[23] != b[23] && dif[23] != t[23];
        set_c = 1'b1;
        set_v = 1'b1;
      end
      SHRSR, SHRSI: begin
        r = shr;
        c_f = shc;
        set_c = 1'b1;
      end
      CMPSR, CMPSI: begin
        wr = 1'b0;
        c_f = dif[24];
        v_f = $signed(t) < $signed(b);
        set_c = 1'b1;
        set_v = 1'b1;
      end
      TSTSR: wr = 1'b0;
      MOVSI: r = imm12;
      MCCSI: begin
        r = taken ? imm8 : '0;
        wr = taken;
        sr_we = taken;
      end
      default: begin
        wr = 1'b0;
        sr_we = 1'b0;
        set_zn = 1'b0;
      end
    endcase
    f = iw_opc == CMPSR || iw_opc == CMPSI ? dif[23:0] : iw_opc == TSTSR ? t : r;
    p = iw_pstate_val;
    if (set_zn) p[1:0] = {f[23], f == 24'd0};
    if (set_c) p[2] = c_f;
    if (set_v) p[3] = v_f;
  end
  always_ff @(posedge iw_clk) begin
    if (iw_rst || (!iw_stall && iw_flush)) begin
      ow_opc <= '0;
      ow_tgt_gp <= '0;
      ow_tgt_gp_we <= 1'b0;
      ow_result <= '0;
      ow_sr_aux_we <= 1'b0;
      ow_sr_aux_result <= '0;
    end else if (!iw_stall) begin
      ow_opc <= iw_opc;
      ow_tgt_gp <= iw_tgt_gp;
      ow_tgt_gp_we <= wr && iw_tgt_gp_we;
      ow_result <= r;
      ow_sr_aux_we <= sr_we;
      ow_sr_aux_result <= p;
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: random and directed checks of stage_ex against an arithmetic reference model
module tb_stage_ex;
  localparam logic [7:0] NEGSR = 8'h10, ADDSR = 8'h11, SUBSR = 8'h12, SHRSR = 8'h13,
                         CMPSR = 8'h14, TSTSR = 8'h15, ADDSI = 8'h20, SUBSI = 8'h21,
                         SHRSI = 8'h22, CMPSI = 8'h23, MOVSI = 8'h24, MCCSI = 8'h25;
  localparam logic [3:0] CC_AL = 4'd0, CC_EQ = 4'd1, CC_NE = 4'd2, CC_LT = 4'd3, CC_GE = 4'd4,
                         CC_MI = 4'd5, CC_PL = 4'd6, CC_CS = 4'd7, CC_CC = 4'd8;
  localparam int unsigned M = 32'hFFFFFF;
  logic        iw_clk = 0, iw_rst = 0, iw_stall = 0, iw_flush = 0, iw_tgt_gp_we = 0;
  logic [7:0]  iw_opc = 0;
  logic [23:0] iw_instr = 0, iw_tgt_gp_val = 0, iw_src_gp_val = 0;
  logic [11:0] iw_imm12_val = 0;
  logic [3:0]  iw_cc = 0, iw_tgt_gp = 0;
  logic [47:0] iw_src_sr_val = 0, iw_pstate_val = 0;
  logic [7:0]  ow_opc;
  logic [3:0]  ow_tgt_gp;
  logic        ow_tgt_gp_we, ow_sr_aux_we;
  logic [23:0] ow_result;
  logic [1:0]  ow_sr_aux_addr;
  logic [47:0] ow_sr_aux_result;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0] opc; logic [3:0] tgt; logic gp_we, sr_we; logic [23:0] res; logic [47:0] sr;
    bit c_tgt, c_res, c_sr;
  } exp_t;
  exp_t e;
  logic [7:0] ops [14] = '{NEGSR, ADDSR, SUBSR, SHRSR, CMPSR, TSTSR, ADDSI, SUBSI,
                           SHRSI, CMPSI, MOVSI, MCCSI, 8'h00, 8'h7F};
  stage_ex dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_stall(iw_stall), .iw_flush(iw_flush),
    .iw_opc(iw_opc), .iw_instr(iw_instr), .iw_imm12_val(iw_imm12_val), .iw_cc(iw_cc),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_gp_val(iw_tgt_gp_val),
    .iw_src_gp_val(iw_src_gp_val), .iw_src_sr_val(iw_src_sr_val), .iw_pstate_val(iw_pstate_val),
    .ow_opc(ow_opc), .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we), .ow_result(ow_result),
    .ow_sr_aux_we(ow_sr_aux_we), .ow_sr_aux_addr(ow_sr_aux_addr), .ow_sr_aux_result(ow_sr_aux_result)
  );
  always #5 iw_clk = ~iw_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int sgn(input int unsigned x);
    return x[23] ? int'(x) - 16777216 : int'(x);
  endfunction
  function automatic exp_t model();
    exp_t m;
    int unsigned tv, bv, r, fv;
    int ts, bs, i12, a;
    bit wr, sw, wz, wc, wv, c, v, tk, use_r;
    logic [3:0] fl;
    fl = iw_src_sr_val[3:0];
    tv = iw_tgt_gp_val;
    i12 = iw_imm12_val[11] ? int'(iw_imm12_val) - 4096 : int'(iw_imm12_val);
    bv = (iw_opc inside {ADDSI, SUBSI, SHRSI, CMPSI, MOVSI}) ? int'(unsigned'(i12)) & M : iw_src_gp_val;
    ts = sgn(tv);
    bs = sgn(bv);
    r = 0; fv = 0; wr = 1; sw = 1; wz = 1; wc = 0; wv = 0; c = 0; v = 0; use_r = 1;
    m.c_res = 1;
    case (iw_opc)
      NEGSR: begin r = (0 - tv) & M; c = tv != 0; v = tv == 32'h800000; wc = 1; wv = 1; end
      ADDSR, ADDSI: begin
        r = (tv + bv) & M; c = tv + bv > M;
        v = ts + bs > 8388607 || ts + bs < -8388608; wc = 1; wv = 1;
      end
      SUBSR, SUBSI: begin
        r = (tv - bv) & M; c = tv < bv;
        v = ts - bs > 8388607 || ts - bs < -8388608; wc = 1; wv = 1;
      end
      SHRSR, SHRSI: begin
        a = int'(bv & 31);
        r = int'(unsigned'(ts >>> a)) & M;
        c = a == 0 ? 0 : ((ts >>> (a - 1)) & 1) != 0; wc = 1;
      end
      CMPSR, CMPSI: begin
        fv = (tv - bv) & M; use_r = 0; c = tv < bv; v = ts < bs;
        wc = 1; wv = 1; wr = 0; m.c_res = 0;
      end
      TSTSR: begin fv = tv; use_r = 0; wr = 0; m.c_res = 0; end
      MOVSI: r = int'(unsigned'(i12)) & M;
      MCCSI: begin
        case (iw_cc)
          CC_AL: tk = 1;
          CC_EQ: tk = fl[0];
          CC_NE: tk = !fl[0];
          CC_LT: tk = fl[1] != fl[3];
          CC_GE: tk = fl[1] == fl[3];
          CC_MI: tk = fl[1];
          CC_PL: tk = !fl[1];
          CC_CS: tk = fl[2];
          CC_CC: tk = !fl[2];
          default: tk = 0;
        endcase
        if (tk) r = (iw_instr[7] ? 32'hFFFF00 : 0) | iw_instr[7:0];
        else begin wr = 0; sw = 0; m.c_res = 0; end
      end
      default: begin wr = 0; sw = 0; end
    endcase
    if (use_r) fv = r;
    m.opc = iw_opc; m.tgt = iw_tgt_gp; m.c_tgt = 1;
    m.gp_we = wr && iw_tgt_gp_we; m.sr_we = sw; m.res = r[23:0]; m.c_sr = sw;
    m.sr = iw_pstate_val;
    if (wz) begin m.sr[0] = fv == 0; m.sr[1] = fv[23]; end
    if (wc) m.sr[2] = c;
    if (wv) m.sr[3] = v;
    return m;
  endfunction
  task automatic step(input bit rs, input bit st, input bit fs);
    iw_rst = rs; iw_stall = st; iw_flush = fs;
    if (rs) e = '{8'h0, 4'h0, 1'b0, 1'b0, 24'h0, 48'h0, 1, 1, 1};
    else if (!st && fs) e = '{8'h0, 4'h0, 1'b0, 1'b0, 24'h0, 48'h0, 0, 1, 0};
    else if (!st) e = model();
    @(posedge iw_clk);
    #1;
    chk("opc", ow_opc, e.opc);
    chk("gp_we", ow_tgt_gp_we, e.gp_we);
    chk("sr_we", ow_sr_aux_we, e.sr_we);
    chk("sr_addr", ow_sr_aux_addr, 2'd2);
    if (e.c_tgt) chk("tgt_gp", ow_tgt_gp, e.tgt);
    if (e.c_res) chk("result", ow_result, e.res);
    if (e.c_sr) chk("sr_result", ow_sr_aux_result, e.sr);
  endtask
  task automatic drive(input logic [7:0] op, input logic [23:0] t, input logic [23:0] s,
                       input logic [11:0] imm, input logic [23:0] ins, input logic [3:0] cc,
                       input logic [47:0] srv, input logic [47:0] ps);
    iw_opc = op; iw_tgt_gp_val = t; iw_src_gp_val = s; iw_imm12_val = imm; iw_instr = ins;
    iw_cc = cc; iw_src_sr_val = srv; iw_pstate_val = ps;
    iw_tgt_gp = 4'($urandom_range(0, 15)); iw_tgt_gp_we = 1;
  endtask
  function automatic logic [23:0] rv();
    case ($urandom_range(0, 5))
      0: return 24'h0;
      1: return 24'h1;
      2: return 24'h7FFFFF;
      3: return 24'h800000;
      4: return 24'hFFFFFF;
      default: return 24'($urandom());
    endcase
  endfunction
  initial begin
    step(1, 0, 0);
    drive(NEGSR, 24'h000001, 0, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("neg_res", ow_result, 24'hFFFFFF); chk("neg_flags", ow_sr_aux_result[3:0], 4'b0110);
    drive(ADDSR, 24'h7FFFFF, 24'h000001, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("add_res", ow_result, 24'h800000); chk("add_flags", ow_sr_aux_result[3:0], 4'b1010);
    drive(SUBSR, 24'h800000, 24'h000001, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("sub_res", ow_result, 24'h7FFFFF); chk("sub_flags", ow_sr_aux_result[3:0], 4'b1000);
    drive(SHRSR, 24'h800002, 24'h000001, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("shr_res", ow_result, 24'hC00001); chk("shr_flags", ow_sr_aux_result[3:0], 4'b0010);
    drive(SHRSI, 24'h800000, 0, 12'h001, 0, 0, 0, 0); step(0, 0, 0);
    chk("shri_res", ow_result, 24'hC00000);
    drive(SHRSR, 24'h800000, 24'h00001F, 0, 0, 0, 0, 48'h8); step(0, 0, 0);
    chk("shr31_res", ow_result, 24'hFFFFFF); chk("shr31_flags", ow_sr_aux_result[3:0], 4'b1110);
    drive(CMPSR, 24'hFFFFFF, 24'h000001, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("cmp_flags", ow_sr_aux_result[3:0], 4'b1010); chk("cmp_gp_we", ow_tgt_gp_we, 0);
    drive(CMPSI, 0, 0, 12'h000, 0, 0, 0, 48'hABC00000000F); step(0, 0, 0);
    chk("cmpi_sr", ow_sr_aux_result, 48'hABC000000001);
    drive(MOVSI, 0, 0, 12'hF80, 0, 0, 0, 0); step(0, 0, 0);
    chk("mov_res", ow_result, 24'hFFFF80); chk("mov_n", ow_sr_aux_result[1], 1);
    drive(MCCSI, 0, 0, 0, 24'h000080, CC_EQ, 48'h1, 0); step(0, 0, 0);
    chk("mcc_res", ow_result, 24'hFFFF80); chk("mcc_z", ow_sr_aux_result[0], 0);
    chk("mcc_we", ow_tgt_gp_we, 1);
    drive(MCCSI, 0, 0, 0, 24'h000080, CC_EQ, 48'h0, 0); step(0, 0, 0);
    chk("mccnt_we", {ow_tgt_gp_we, ow_sr_aux_we}, 2'b00);
    drive(ADDSR, 24'h000005, 24'h000003, 0, 0, 0, 0, 0); step(0, 0, 0);
    drive(NEGSR, 24'h000123, 0, 0, 0, 0, 0, 0); step(0, 1, 0);
    chk("stall_res", ow_result, 24'h000008);
    step(0, 0, 1);
    chk("flush_we", {ow_tgt_gp_we, ow_sr_aux_we}, 2'b00);
    drive(SUBSI, 24'h000010, 0, 12'hFFF, 0, 0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drive(ops[$urandom_range(0, 13)], rv(), rv(), 12'($urandom()), 24'($urandom()),
            4'($urandom_range(0, 9)), 48'($urandom()), {16'($urandom()), 32'($urandom())});
      iw_tgt_gp_we = 1'($urandom());
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
